// File: rtl/issue_scheduler_if.sv
// Fetch-side pair handshake and even/odd pipe issue bundle for issue_scheduler.
// master = fetch/pipe side that drives the pair and the stall controls, slave = scheduler.
interface issue_scheduler_if #(
   parameter int INST_WIDTH = 32
);
   logic                    pair_valid;
   logic [2*INST_WIDTH-1:0] pair_data;
   logic                    pair_ready;
   logic                    pipe_hold;
   logic                    flush;
   logic                    even_valid;
   logic [INST_WIDTH-1:0]   even_inst;
   logic                    odd_valid;
   logic [INST_WIDTH-1:0]   odd_inst;
   logic [15:0]             split_count;

   modport master (
      output pair_valid, pair_data, pipe_hold, flush,
      input  pair_ready, even_valid, even_inst, odd_valid, odd_inst, split_count
   );

   modport slave (
      input  pair_valid, pair_data, pipe_hold, flush,
      output pair_ready, even_valid, even_inst, odd_valid, odd_inst, split_count
   );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: steers an instruction pair to even/odd pipes by opcode parity.
// Define DUAL_ISSUE_EN for dual issue; without it every two-instruction pair is split.
module issue_scheduler #(
   parameter int INST_WIDTH = 32,
   parameter int MUL_OPCODE = 20,
   parameter int MUL_BUSY   = 1
) (
   input logic              clk,
   input logic              reset,
   issue_scheduler_if.slave bus
);
   localparam logic [INST_WIDTH-1:0] NOP = '1;
   localparam int OP_LSB = INST_WIDTH - 6;

   typedef enum logic {EMPTY, PEND} state_t;

   state_t                state_reg, state_next;
   logic [INST_WIDTH-1:0] pending_reg, pending_next;
   logic [2:0]            busy_reg, busy_next;
   logic                  even_valid_reg, even_valid_next;
   logic [INST_WIDTH-1:0] even_inst_reg, even_inst_next;
   logic                  odd_valid_reg, odd_valid_next;
   logic [INST_WIDTH-1:0] odd_inst_reg, odd_inst_next;
   logic [15:0]           split_reg, split_next;

   logic                  pair_ready;
   logic                  accept;
   logic                  conflict;
   logic [INST_WIDTH-1:0] slot_inst [2];
   logic [1:0]            slot_real;
   logic [1:0]            slot_odd;

   // Slot 0 is the older instruction and always issues first on a split.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         assign slot_inst[gi] = bus.pair_data[gi*INST_WIDTH +: INST_WIDTH];
         assign slot_real[gi] = (slot_inst[gi] != NOP);
         assign slot_odd[gi]  = slot_inst[gi][OP_LSB];
      end
   endgenerate

`ifdef DUAL_ISSUE_EN
   assign conflict = (&slot_real) && (slot_odd[0] == slot_odd[1]);
`else
   assign conflict = &slot_real;
`endif

   assign pair_ready = (state_reg == EMPTY) && !bus.pipe_hold && !bus.flush &&
                       (busy_reg == 3'd0) && !reset;
   assign accept     = bus.pair_valid && pair_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= EMPTY;
         pending_reg    <= NOP;
         busy_reg       <= 3'd0;
         even_valid_reg <= 1'b0;
         even_inst_reg  <= NOP;
         odd_valid_reg  <= 1'b0;
         odd_inst_reg   <= NOP;
         split_reg      <= 16'd0;
      end else begin
         state_reg      <= state_next;
         pending_reg    <= pending_next;
         busy_reg       <= busy_next;
         even_valid_reg <= even_valid_next;
         even_inst_reg  <= even_inst_next;
         odd_valid_reg  <= odd_valid_next;
         odd_inst_reg   <= odd_inst_next;
         split_reg      <= split_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pending_next    = pending_reg;
      busy_next       = (busy_reg != 3'd0) ? busy_reg - 3'd1 : 3'd0;
      even_valid_next = 1'b0;
      even_inst_next  = NOP;
      odd_valid_next  = 1'b0;
      odd_inst_next   = NOP;
      split_next      = split_reg;

      if (bus.flush) begin
         state_next   = EMPTY;
         pending_next = NOP;
         busy_next    = 3'd0;
      end else if (!bus.pipe_hold) begin
         if (accept) begin
            for (int i = 0; i < 2; i++) begin
               if (slot_real[i] && !(conflict && i == 1)) begin
                  if (slot_odd[i]) begin
                     odd_valid_next = 1'b1;
                     odd_inst_next  = slot_inst[i];
                  end else begin
                     even_valid_next = 1'b1;
                     even_inst_next  = slot_inst[i];
                  end
               end
            end
            if (conflict) begin
               state_next   = PEND;
               pending_next = slot_inst[1];
               split_next   = split_reg + 16'd1;
            end
         end else if (state_reg == PEND) begin
            // The multiply only blocks the even pipe; odd leftovers go straight out.
            if (pending_reg[OP_LSB]) begin
               odd_valid_next = 1'b1;
               odd_inst_next  = pending_reg;
               state_next     = EMPTY;
               pending_next   = NOP;
            end else if (busy_reg == 3'd0) begin
               even_valid_next = 1'b1;
               even_inst_next  = pending_reg;
               state_next      = EMPTY;
               pending_next    = NOP;
            end
         end
      end

      if (even_valid_next && (even_inst_next[INST_WIDTH-1 -: 6] == 6'(MUL_OPCODE)))
         busy_next = 3'(MUL_BUSY);
   end

   assign bus.pair_ready  = pair_ready;
   assign bus.even_valid  = even_valid_reg;
   assign bus.even_inst   = even_inst_reg;
   assign bus.odd_valid   = odd_valid_reg;
   assign bus.odd_inst    = odd_inst_reg;
   assign bus.split_count = split_reg;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler (MUL_BUSY=1); expectations follow DUAL_ISSUE_EN.
module tb_issue_scheduler;
   localparam logic [31:0] NOP = 32'hFFFF_FFFF;
`ifdef DUAL_ISSUE_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_split;
   logic [65:0] exp_outs;

   always #5 clk = ~clk;

   issue_scheduler_if #(.INST_WIDTH(32)) bus ();

   issue_scheduler #(
      .INST_WIDTH(32),
      .MUL_OPCODE(20),
      .MUL_BUSY  (1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   function automatic logic [65:0] outs();
      return {bus.even_valid, bus.even_inst, bus.odd_valid, bus.odd_inst};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.pair_valid = 1'b0;
      bus.pair_data  = {NOP, NOP};
   endtask

   task automatic present(input logic [31:0] hi, input logic [31:0] lo);
      bus.pair_valid = 1'b1;
      bus.pair_data  = {hi, lo};
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.pipe_hold = 1'b0;
      bus.flush     = 1'b0;
      drive_idle();
      step();
      step();
      exp_split = 16'd0;
      $display("test_reset: reset held two cycles");
      exp_outs = {1'b0, NOP, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL reset_outs: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.split_count !== 16'd0) begin n_fail++; $display("FAIL reset_split: got %0d want 0", bus.split_count); end
      n_checks++;
      if (bus.pair_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", bus.pair_ready); end
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.pair_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %b want 1", bus.pair_ready); end
   endtask

   task automatic test_dual_pair();
      present(32'h1400_0001, 32'h1000_0002);
      step();
      drive_idle();
      exp_split += DUAL ? 16'd0 : 16'd1;
      $display("test_dual_pair: accepted {14000001,10000002}");
      exp_outs = {1'b1, 32'h1000_0002, DUAL, (DUAL ? 32'h1400_0001 : NOP)};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL dual_c1: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.split_count !== exp_split) begin n_fail++; $display("FAIL dual_split: got %0d want %0d", bus.split_count, exp_split); end
      step();
      exp_outs = {1'b0, NOP, ~DUAL, (DUAL ? NOP : 32'h1400_0001)};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL dual_c2: got %h want %h", outs(), exp_outs); end
   endtask

   task automatic test_split();
      present(32'h2000_0005, 32'h1000_0002);
      step();
      drive_idle();
      exp_split += 16'd1;
      $display("test_split: accepted {20000005,10000002}");
      exp_outs = {1'b1, 32'h1000_0002, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL split_c1: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b0) begin n_fail++; $display("FAIL split_ready_c1: got %b want 0", bus.pair_ready); end
      step();
      exp_outs = {1'b1, 32'h2000_0005, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL split_c2: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.split_count !== exp_split) begin n_fail++; $display("FAIL split_count: got %0d want %0d", bus.split_count, exp_split); end
      n_checks++;
      if (bus.pair_ready !== 1'b1) begin n_fail++; $display("FAIL split_ready_c2: got %b want 1", bus.pair_ready); end
   endtask

   task automatic test_mul();
      present(32'h1000_0001, 32'h5000_0000);
      step();
      drive_idle();
      exp_split += 16'd1;
      $display("test_mul: accepted {10000001,50000000}");
      exp_outs = {1'b1, 32'h5000_0000, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL mul_c1: got %h want %h", outs(), exp_outs); end
      step();
      exp_outs = {1'b0, NOP, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL mul_c2_blocked: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b0) begin n_fail++; $display("FAIL mul_ready_c2: got %b want 0", bus.pair_ready); end
      step();
      exp_outs = {1'b1, 32'h1000_0001, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL mul_c3: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.split_count !== exp_split) begin n_fail++; $display("FAIL mul_split: got %0d want %0d", bus.split_count, exp_split); end

      present(32'h1400_0001, 32'h5000_0000);
      step();
      drive_idle();
      exp_split += DUAL ? 16'd0 : 16'd1;
      $display("test_mul: accepted {14000001,50000000}");
      exp_outs = {1'b1, 32'h5000_0000, DUAL, (DUAL ? 32'h1400_0001 : NOP)};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL mulodd_c1: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b0) begin n_fail++; $display("FAIL mulodd_ready_c1: got %b want 0", bus.pair_ready); end
      step();
      exp_outs = {1'b0, NOP, ~DUAL, (DUAL ? NOP : 32'h1400_0001)};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL mulodd_c2: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b1) begin n_fail++; $display("FAIL mulodd_ready_c2: got %b want 1", bus.pair_ready); end
      n_checks++;
      if (bus.split_count !== exp_split) begin n_fail++; $display("FAIL mulodd_split: got %0d want %0d", bus.split_count, exp_split); end
   endtask

   task automatic test_flush();
      present(32'h2000_0005, 32'h1000_0002);
      step();
      drive_idle();
      bus.flush = 1'b1;
      exp_split += 16'd1;
      $display("test_flush: split pair accepted, flush in cycle 1");
      exp_outs = {1'b1, 32'h1000_0002, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL flush_c1: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_c1: got %b want 0", bus.pair_ready); end
      step();
      bus.flush = 1'b0;
      #1;
      exp_outs = {1'b0, NOP, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL flush_c2: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_c2: got %b want 1", bus.pair_ready); end
      n_checks++;
      if (bus.split_count !== exp_split) begin n_fail++; $display("FAIL flush_split: got %0d want %0d", bus.split_count, exp_split); end
      step();
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL flush_c3: got %h want %h", outs(), exp_outs); end
   endtask

   task automatic test_nop_pair();
      present(NOP, NOP);
      step();
      drive_idle();
      $display("test_nop_pair: accepted all-NOP pair");
      exp_outs = {1'b0, NOP, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL nop_c1: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.split_count !== exp_split) begin n_fail++; $display("FAIL nop_split: got %0d want %0d", bus.split_count, exp_split); end
      present(32'h1400_0001, NOP);
      step();
      drive_idle();
      $display("test_nop_pair: accepted {14000001,NOP}");
      exp_outs = {1'b0, NOP, 1'b1, 32'h1400_0001};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL nop_slot0: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b1) begin n_fail++; $display("FAIL nop_ready: got %b want 1", bus.pair_ready); end
   endtask

   task automatic test_hold();
      present(32'h2000_0005, 32'h1000_0002);
      step();
      drive_idle();
      bus.pipe_hold = 1'b1;
      exp_split += 16'd1;
      $display("test_hold: split pair accepted, hold for 3 cycles");
      exp_outs = {1'b1, 32'h1000_0002, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL hold_c1: got %h want %h", outs(), exp_outs); end
      exp_outs = {1'b0, NOP, 1'b0, NOP};
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++;
         if (outs() !== exp_outs) begin n_fail++; $display("FAIL hold_c%0d: got %h want %h", k + 2, outs(), exp_outs); end
         n_checks++;
         if (bus.pair_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_c%0d: got %b want 0", k + 2, bus.pair_ready); end
      end
      step();
      bus.pipe_hold = 1'b0;
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL hold_c4: got %h want %h", outs(), exp_outs); end
      step();
      exp_outs = {1'b1, 32'h2000_0005, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL hold_c5: got %h want %h", outs(), exp_outs); end
   endtask

   task automatic test_reset_pend();
      present(32'h2000_0005, 32'h1000_0002);
      step();
      drive_idle();
      reset = 1'b1;
      $display("test_reset_pend: reset while pending");
      step();
      reset = 1'b0;
      exp_split = 16'd0;
      exp_outs = {1'b0, NOP, 1'b0, NOP};
      n_checks++;
      if (bus.split_count !== exp_split) begin n_fail++; $display("FAIL rstpend_split: got %0d want 0", bus.split_count); end
      step();
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL rstpend_discard: got %h want %h", outs(), exp_outs); end
      n_checks++;
      if (bus.pair_ready !== 1'b1) begin n_fail++; $display("FAIL rstpend_ready: got %b want 1", bus.pair_ready); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] his [3];
      logic [31:0] los [3];
      logic [65:0] exps [3];
      his  = '{NOP, 32'h1400_0001, NOP};
      los  = '{32'h1000_0002, NOP, 32'h1800_0004};
      exps = '{{1'b1, 32'h1000_0002, 1'b0, NOP},
               {1'b0, NOP, 1'b1, 32'h1400_0001},
               {1'b1, 32'h1800_0004, 1'b0, NOP}};
      for (int i = 0; i < 3; i++) begin
         present(his[i], los[i]);
         #1;
         n_checks++;
         if (bus.pair_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.pair_ready); end
         step();
         $display("test_back_to_back: pair %0d {%h,%h}", i, his[i], los[i]);
         n_checks++;
         if (outs() !== exps[i]) begin n_fail++; $display("FAIL b2b_out_%0d: got %h want %h", i, outs(), exps[i]); end
      end
      drive_idle();
      step();
      exp_outs = {1'b0, NOP, 1'b0, NOP};
      n_checks++;
      if (outs() !== exp_outs) begin n_fail++; $display("FAIL b2b_idle: got %h want %h", outs(), exp_outs); end
   endtask

   initial begin
      test_reset();
      test_dual_pair();
      test_split();
      test_mul();
      test_flush();
      test_nop_pair();
      test_hold();
      test_reset_pend();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue scheduler between the instruction-pair fetch buffer and the even/odd execution pipes. It accepts one 64-bit instruction pair per handshake and steers each instruction to the pipe selected by opcode parity. A pair is split over two cycles when both instructions need the same pipe. Even-pipe issue is blocked while a multi-cycle multiply occupies that pipe.

## Interface
Parameters:
- INST_WIDTH, 32, instruction word width; opcode is inst[31:26].
- MUL_OPCODE, 20, even-pipe opcode that occupies the even pipe for extra cycles.
- MUL_BUSY, 1, extra cycles the even pipe is blocked after a MUL_OPCODE issue (0–7).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- pair_valid  in  1  fetch presents a pair.
- pair_data  in  64  [31:0] = inst0 (older), [63:32] = inst1.
- pair_ready  out  1  combinational: (state==EMPTY) && !pipe_hold && !flush && busy_cnt==0 && !reset.
- pipe_hold  in  1  downstream stall: no issue this cycle.
- flush  in  1  discard pending instruction and busy state.
- even_valid  out  1  even-pipe issue pulse.
- even_inst  out  32  instruction issued to the even pipe.
- odd_valid  out  1  odd-pipe issue pulse.
- odd_inst  out  32  instruction issued to the odd pipe.
- split_count  out  16  pairs split so far; wraps 0xFFFF→0.

## Operation
- Word 32'hFFFFFFFF is a NOP (empty slot). It is never issued and never causes a split.
- Pipe select: opcode[0]==0 → even pipe; opcode[0]==1 → odd pipe.
- States: EMPTY (no pending instruction), PEND (inst1 held in the pending register).
- Accept happens when pair_valid && pair_ready.
  - No conflict (different pipes, or either slot a NOP): issue all non-NOP slots together. State stays EMPTY.
  - Conflict (both non-NOP, same pipe): issue inst0, store inst1 as pending, go to PEND, increment split_count.
- In PEND, when !pipe_hold and the target pipe is free: issue the pending instruction and go to EMPTY.
  - An odd-pipe pending instruction ignores busy_cnt.
- busy_cnt (3 bits):
  - Loaded with MUL_BUSY when the even pipe issues MUL_OPCODE.
  - Otherwise decrements every cycle while nonzero, including during pipe_hold.
  - Even-pipe issue requires busy_cnt==0 before the edge.
- Outputs:
  - Valids are asserted for exactly one cycle per issue; 0 in every cycle with no issue.
  - An inst output equals 32'hFFFFFFFF whenever its valid is 0.
- pipe_hold: no issue, no accept, valids 0; state and pending register unchanged.
- Priority order: reset > flush > pipe_hold > issue/accept.
  - flush: state to EMPTY, pending cleared to NOP, busy_cnt to 0, valids 0.
  - flush does not clear split_count.
- Reset: valids 0, inst outputs 32'hFFFFFFFF, split_count 0, state EMPTY, busy_cnt 0, pending NOP.
  - Reset mid-PEND discards the pending instruction.

## Timing
- Accept at edge N → issue outputs valid during cycle N+1 (1-cycle latency, registered outputs).
- Split pair: inst0 issued in cycle N+1, inst1 in cycle N+2 at earliest. pair_ready is low during cycle N+1.
- Multiply: MUL_OPCODE issued at edge M → next even issue at edge M+1+MUL_BUSY at earliest.
- A pair containing MUL_OPCODE plus an odd instruction issues both in the same cycle.
- Back-to-back non-conflicting pairs sustain one pair per cycle.

## Configuration
- DUAL_ISSUE_EN defined: behaviour as above.
- DUAL_ISSUE_EN undefined: single-issue mode.
  - Every pair with two non-NOP instructions is split (inst0 first, then inst1), regardless of pipe.
  - split_count counts all such pairs.
  - All other rules are unchanged.

## Test plan
- Accept {hi=0x14000001, lo=0x10000002} → next cycle even_valid=1, even_inst=0x10000002, odd_valid=1, odd_inst=0x14000001; split_count=0.
- Accept {hi=0x20000005, lo=0x10000002} → cycle 1: even_inst=0x10000002, pair_ready=0; cycle 2: even_inst=0x20000005, odd_valid=0; split_count=1.
- MUL_BUSY=1, accept {hi=0x10000001, lo=0x50000000} → cycle 1: even mul issued; cycle 2: no issue; cycle 3: even_inst=0x10000001.
- Split pair with flush asserted in cycle 1 → cycle 2 no issue; pair_ready=1 in cycle 2; split_count=1.
- Pair {hi=0xFFFFFFFF, lo=0xFFFFFFFF} accepted → no valids.
- pipe_hold high for 3 cycles during PEND → no issue, valids 0; pending issues in the cycle after hold drops.
- DUAL_ISSUE_EN undefined, pair from test 1 → even issue in cycle 1, odd issue in cycle 2; split_count=1.
